mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_starve_cnt.sv | 31 +++
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the unified memory port arbiter
package mem_arb_pkg;

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// rtl/mem_arb_starve_cnt.sv - saturating count of D grants taken while a fetch waits
module mem_arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             grant_i,
    input  logic             grant_d,
    input  logic             i_pending,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (grant_i) begin
            cnt <= '0;
        end else if (grant_d) begin
            if (!i_pending) begin
                cnt <= '0;
            end else if (cnt < LIMIT) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one synchronous memory between fetch (I) and load/store (D)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LAT_LAST   = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_t       state, state_nx;
    arb_owner_t       owner, owner_nx;
    logic [CNT_W-1:0] lat_cnt, lat_nx;
    logic [CNT_W-1:0] starve_cnt;
    logic             idle;
    logic             grant_d;
    logic             grant_i;

    // Grants are gated by rst_n so an asserted reset silences the port at once.
    assign idle    = rst_n && (state == IDLE);
    assign grant_d = idle && d_req && (!i_req || (starve_cnt < STARVE_LIM));
    assign grant_i = idle && i_req && !grant_d;

    mem_arb_starve_cnt #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .grant_i  (grant_i),
        .grant_d  (grant_d),
        .i_pending(i_req),
        .cnt      (starve_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= OWN_I;
            lat_cnt <= '0;
        end else begin
            state   <= state_nx;
            owner   <= owner_nx;
            lat_cnt <= lat_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        owner_nx  = owner;
        lat_nx    = lat_cnt;
        i_ready   = grant_i;
        d_ready   = grant_d;
        i_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        i_rdata   = '0;
        d_rdata   = '0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    mem_addr  = d_addr;
                    mem_wen   = d_wen;
                    mem_wdata = d_wdata;
                end else if (grant_i) begin
                    mem_addr = i_addr;
                end
                // Stores complete at the grant edge; only reads hold the port.
                if (grant_i || (grant_d && !d_wen)) begin
                    owner_nx = grant_d ? OWN_D : OWN_I;
                    lat_nx   = CNT_W'(1);
                    state_nx = (RD_LAT == 1) ? RD_DONE : RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    state_nx = RD_DONE;
                end else begin
                    lat_nx = lat_cnt + CNT_W'(1);
                end
            end
            RD_DONE: begin
                if (owner == OWN_D) begin
                    d_rvalid = 1'b1;
                    d_rdata  = mem_rdata;
                end else begin
                    i_rvalid = 1'b1;
                    i_rdata  = mem_rdata;
                end
                state_nx = IDLE;
                lat_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                lat_nx   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter against a timestamp model
module tb_mem_port_arbiter;

    localparam int SMAX     = 4;
    localparam int RAND_CYC = 1500;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit done [2];

    task automatic chk(input int e, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL env%0d %s: got %0h expected %0h", e, name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] rnd_addr();
        return 32'h0001_0000 + 32'($urandom_range(0, 7)) * 4;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : env
        localparam int LAT = (g == 0) ? 1 : 3;

        logic        rst_n   = 1'b0;
        logic        i_req   = 1'b0;
        logic [31:0] i_addr  = '0;
        logic        d_req   = 1'b0;
        logic        d_wen   = 1'b0;
        logic [31:0] d_addr  = '0;
        logic [31:0] d_wdata = '0;
        logic        i_ready, i_rvalid, d_ready, d_rvalid, mem_wen;
        logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

        mem_port_arbiter #(
            .ADDR_W(32), .DATA_W(32), .RD_LAT(LAT), .STARVE_MAX(SMAX)
        ) dut (
            .clk(clk), .rst_n(rst_n),
            .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
            .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
            .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
            .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
        );

        // Memory attached to the port: read data appears LAT edges after the grant edge.
        logic [31:0] mem [logic [31:0]];
        logic [31:0] ref_mem [logic [31:0]];
        logic [31:0] pipe [LAT];

        function automatic logic [31:0] mem_rd(input logic [31:0] a);
            return mem.exists(a) ? mem[a] : init_val(a);
        endfunction

        function automatic logic [31:0] ref_rd(input logic [31:0] a);
            return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
        endfunction

        always @(posedge clk) begin
            for (int k = LAT - 1; k > 0; k--) pipe[k] = pipe[k-1];
            pipe[0] = ((i_ready || d_ready) && !mem_wen) ? mem_rd(mem_addr) : $urandom;
            if (mem_wen) mem[mem_addr] = mem_wdata;
        end
        assign mem_rdata = pipe[LAT-1];

        // Reference: the port is free unless a read is outstanding; a read granted
        // in cycle t delivers its data in cycle t+LAT.
        int          cyc    = 0;
        int          rd_due = -1;
        int          starve = 0;
        bit          rd_own_d;
        logic [31:0] rd_val;

        always @(negedge clk) begin
            logic        e_ir, e_dr, e_iv, e_dv, e_mw;
            logic [31:0] e_ird, e_drd, e_ma, e_mwd;
            {e_ir, e_dr, e_iv, e_dv, e_mw} = '0;
            {e_ird, e_drd, e_ma, e_mwd}    = '0;
            if (!rst_n) begin
                rd_due = -1;
                starve = 0;
            end else if (rd_due == cyc) begin
                if (rd_own_d) begin e_dv = 1'b1; e_drd = rd_val; end
                else          begin e_iv = 1'b1; e_ird = rd_val; end
                rd_due = -1;
            end else if (rd_due < 0) begin
                if (d_req && (!i_req || starve < SMAX)) begin
                    e_dr  = 1'b1;
                    e_ma  = d_addr;
                    e_mw  = d_wen;
                    e_mwd = d_wdata;
                    starve = i_req ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
                    if (d_wen) ref_mem[d_addr] = d_wdata;
                    else begin rd_due = cyc + LAT; rd_own_d = 1'b1; rd_val = ref_rd(d_addr); end
                end else if (i_req) begin
                    e_ir   = 1'b1;
                    e_ma   = i_addr;
                    starve = 0;
                    rd_due = cyc + LAT;
                    rd_own_d = 1'b0;
                    rd_val = ref_rd(i_addr);
                end
            end
            chk(g, "m_ctl", {i_ready, d_ready, i_rvalid, d_rvalid, mem_wen}, {e_ir, e_dr, e_iv, e_dv, e_mw});
            chk(g, "m_bus", {mem_addr, mem_wdata}, {e_ma, e_mwd});
            chk(g, "m_rdata", {i_rdata, d_rdata}, {e_ird, e_drd});
            cyc++;
        end

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        task automatic preload(input logic [31:0] a, input logic [31:0] v);
            mem[a]     = v;
            ref_mem[a] = v;
        endtask

        initial begin
            bit ia, da;
            int k;
            repeat (2) @(posedge clk);
            #1 i_req = 1'b1; d_req = 1'b1;
            #2 chk(g, "rst_ctl", {i_ready, d_ready, i_rvalid, d_rvalid, mem_wen}, 0);
            chk(g, "rst_bus", {mem_addr, mem_wdata}, 0);
            i_req = 1'b0; d_req = 1'b0;
            step();
            rst_n = 1'b1;

            // Single fetch.
            preload(32'h0001_0000, 32'h0000_0013);
            i_req = 1'b1; i_addr = 32'h0001_0000;
            #2 chk(g, "t1_ready", i_ready, 1);
            step(); i_req = 1'b0;
            repeat (LAT - 1) begin #2 chk(g, "t1_wait", {i_ready, i_rvalid, mem_addr}, 0); step(); end
            #2 chk(g, "t1_rvalid", i_rvalid, 1);
            chk(g, "t1_rdata", i_rdata, 32'h0000_0013);
            step(); i_req = 1'b1; i_addr = 32'h0001_0004;
            #2 chk(g, "t1_free", i_ready, 1);
            step(); i_req = 1'b0; repeat (LAT) step();

            // Simultaneous requests: D wins, I follows the load.
            preload(32'h0001_0088, 32'h0bad_f00d);
            i_req = 1'b1; i_addr = 32'h0001_0008;
            d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h0001_0088;
            #2 chk(g, "t2_grant", {d_ready, i_ready}, 2'b10);
            step(); d_req = 1'b0;
            repeat (LAT - 1) begin #2 chk(g, "t2_hold", i_ready, 0); step(); end
            #2 chk(g, "t2_rvalid", {d_rvalid, i_ready}, 2'b10);
            chk(g, "t2_rdata", d_rdata, 32'h0bad_f00d);
            step();
            #2 chk(g, "t2_i_grant", i_ready, 1);
            step(); i_req = 1'b0; repeat (LAT) step();

            // Store burst against a waiting fetch: four stores, then the fetch.
            k = 0;
            i_req = 1'b1; i_addr = 32'h0001_000c;
            d_req = 1'b1; d_wen = 1'b1;
            for (int c = 0; c < 6 + LAT; c++) begin
                d_addr  = 32'h0001_0088 + 32'(k) * 4;
                d_wdata = 32'(k);
                #2 chk(g, "t3_d_ready", d_ready, ((c < 4) || (c == 5 + LAT)) ? 1 : 0);
                chk(g, "t3_i_ready", i_ready, (c == 4) ? 1 : 0);
                ia = i_ready; da = d_ready;
                step();
                if (ia) i_req = 1'b0;
                if (da) begin k++; if (k == 5) d_req = 1'b0; end
            end
            d_req = 1'b0;
            for (int j = 0; j < 5; j++) chk(g, "t3_mem", mem_rd(32'h0001_0088 + 32'(j) * 4), j);

            // Store then load of the same word.
            d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h0001_0090; d_wdata = 32'hdead_beef;
            #2 chk(g, "t6_store", {d_ready, mem_wen, d_rvalid}, 3'b110);
            chk(g, "t6_store_bus", {mem_addr, mem_wdata}, {32'h0001_0090, 32'hdead_beef});
            step(); d_wen = 1'b0; d_wdata = '0;
            #2 chk(g, "t6_load", {d_ready, mem_wen, d_rvalid}, 3'b100);
            step(); d_req = 1'b0;
            repeat (LAT - 1) begin #2 chk(g, "t6_wait", {d_rvalid, mem_wen}, 0); step(); end
            #2 chk(g, "t6_rvalid", d_rvalid, 1);
            chk(g, "t6_rdata", d_rdata, 32'hdead_beef);
            step();

            // Load with a fetch arriving while it is outstanding.
            preload(32'hbfff_ffe0, 32'h1234_5678);
            d_req = 1'b1; d_wen = 1'b0; d_addr = 32'hbfff_ffe0;
            #2 chk(g, "t4_grant", d_ready, 1);
            step(); d_req = 1'b0; i_req = 1'b1; i_addr = 32'h0001_0010;
            repeat (LAT - 1) begin
                #2 chk(g, "t4_idle_bus", {mem_addr, mem_wdata}, 0);
                chk(g, "t4_idle_ctl", {mem_wen, i_ready, d_rvalid}, 0);
                step();
            end
            #2 chk(g, "t4_rvalid", {d_rvalid, i_ready}, 2'b10);
            chk(g, "t4_rdata", d_rdata, 32'h1234_5678);
            step();
            #2 chk(g, "t4_i_grant", i_ready, 1);
            step(); i_req = 1'b0; repeat (LAT) step();

            // Asynchronous reset while a load is outstanding.
            d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h0001_0014;
            #2 chk(g, "t5_grant", d_ready, 1);
            step(); d_req = 1'b0; i_req = 1'b1; i_addr = 32'h0001_0018;
            #1 rst_n = 1'b0;
            #1 chk(g, "t5_rst_ctl", {i_ready, d_ready, i_rvalid, d_rvalid, mem_wen}, 0);
            chk(g, "t5_rst_bus", {mem_addr, mem_wdata}, 0);
            chk(g, "t5_rst_rdata", {i_rdata, d_rdata}, 0);
            step(); step();
            rst_n = 1'b1;
            #2 chk(g, "t5_after", {i_ready, d_rvalid}, 2'b10);
            step(); i_req = 1'b0;
            repeat (LAT + 1) begin #2 chk(g, "t5_no_drvalid", d_rvalid, 0); step(); end

            // Randomized traffic, including withdrawn requests.
            ia = 1'b0; da = 1'b0;
            for (int c = 0; c < RAND_CYC; c++) begin
                step();
                if (!i_req || ia) begin
                    i_req  = ($urandom_range(0, 9) < 5);
                    i_addr = rnd_addr();
                end else if ($urandom_range(0, 15) == 0) begin
                    i_req = 1'b0;
                end
                if (!d_req || da) begin
                    d_req   = ($urandom_range(0, 9) < 8);
                    d_wen   = 1'($urandom_range(0, 1));
                    d_addr  = rnd_addr();
                    d_wdata = $urandom;
                end else if ($urandom_range(0, 15) == 0) begin
                    d_req = 1'b0;
                end
                #2 ia = i_ready; da = d_ready;
            end
            step();
            i_req = 1'b0; d_req = 1'b0;
            repeat (LAT + 2) step();
            done[g] = 1'b1;
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(done[0] && done[1]) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (!(done[0] && done[1])) begin
            errors++;
            $display("FAIL timeout: done=%0d%0d expected 11", done[0], done[1]);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
